// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (F) and
// load/store (D). Each port's one-cycle strobe is latched into a pending slot.
// Pending slots are granted round-robin. The memory request is held until
// mem_valid or a timeout, and the owner then gets a one-cycle response pulse.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   f_req, f_addr              fetch strobe and address
//   f_valid, f_rdata, f_err    fetch response pulse, data, timeout flag
//   d_req, d_addr, d_wdata,    load/store strobe, address, store data,
//   d_wstrb                    byte strobes (0000 = load)
//   d_valid, d_rdata, d_err    load/store response pulse, data, timeout flag
//   overrun                    pulse: a strobe was dropped
//   busy                       transaction in flight or a slot pending
//   mem_ready, mem_addr,       memory request and its payload, held stable
//   mem_wdata, mem_wstrb,      while waiting
//   mem_instr                  transaction belongs to F
//   mem_valid, mem_rdata       memory response

package mem_arbiter_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Payload of one memory transaction
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_req_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_valid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [SW-1:0] d_wstrb,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          overrun,
  output logic          busy,
  output logic          mem_ready,
  input  logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_wstrb,
  output logic          mem_instr,
  input  logic [DW-1:0] mem_rdata
);

  // Last counter value before a silent memory is abandoned
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_n;
  logic             pend_f, pend_f_n;
  logic             pend_d, pend_d_n;
  logic [AW-1:0]    f_slot, f_slot_n;
  mem_req_t         d_slot, d_slot_n;
  logic             owner_d, owner_d_n;   // 1: D owns the transaction in flight
  logic             last_d, last_d_n;     // 1: D was granted last
  logic [CNT_W-1:0] cnt, cnt_n;
  mem_req_t         mem_req, mem_req_n;
  logic             mem_ready_n, mem_instr_n;
  logic             f_valid_n, f_err_n, d_valid_n, d_err_n;
  logic [DW-1:0]    f_rdata_n, d_rdata_n;
  logic             overrun_n, busy_n;

  logic             resp_hit, resp_tmo, grant_d;
  logic             f_owns, d_owns, f_drop, d_drop;
  logic [DW-1:0]    resp_data;

  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_wstrb = mem_req.wstrb;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend_f    <= 1'b0;
      pend_d    <= 1'b0;
      f_slot    <= '0;
      d_slot    <= '0;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      cnt       <= '0;
      mem_req   <= '0;
      mem_ready <= 1'b0;
      mem_instr <= 1'b0;
      f_valid   <= 1'b0;
      f_rdata   <= '0;
      f_err     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      pend_f    <= pend_f_n;
      pend_d    <= pend_d_n;
      f_slot    <= f_slot_n;
      d_slot    <= d_slot_n;
      owner_d   <= owner_d_n;
      last_d    <= last_d_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_ready <= mem_ready_n;
      mem_instr <= mem_instr_n;
      f_valid   <= f_valid_n;
      f_rdata   <= f_rdata_n;
      f_err     <= f_err_n;
      d_valid   <= d_valid_n;
      d_rdata   <= d_rdata_n;
      d_err     <= d_err_n;
      overrun   <= overrun_n;
      busy      <= busy_n;
    end
  end

  // Next state: capture, arbitration, wait/timeout, response routing
  always_comb begin
    state_n     = state;
    pend_f_n    = pend_f;
    pend_d_n    = pend_d;
    f_slot_n    = f_slot;
    d_slot_n    = d_slot;
    owner_d_n   = owner_d;
    last_d_n    = last_d;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_ready_n = mem_ready;
    mem_instr_n = mem_instr;
    f_valid_n   = 1'b0;
    f_rdata_n   = f_rdata;
    f_err_n     = 1'b0;
    d_valid_n   = 1'b0;
    d_rdata_n   = d_rdata;
    d_err_n     = 1'b0;
    resp_hit    = 1'b0;
    resp_tmo    = 1'b0;
    grant_d     = 1'b0;
    resp_data   = '0;

    if (state == WAIT) begin
      if (mem_valid) begin
        resp_hit = 1'b1;
      end else if (TO_EN && (cnt == TO_LAST)) begin
        resp_tmo = 1'b1;
      end
    end

    // Ownership ends on the edge the response is delivered
    f_owns = (state == WAIT) && !owner_d && !(resp_hit || resp_tmo);
    d_owns = (state == WAIT) &&  owner_d && !(resp_hit || resp_tmo);
    f_drop = f_req && (pend_f || f_owns);
    d_drop = d_req && (pend_d || d_owns);

    case (state)
      IDLE: begin
        if (pend_f || pend_d) begin
          // On a tie the port not granted last wins
          grant_d = pend_d && (!pend_f || !last_d);
          if (grant_d) begin
            mem_req_n   = d_slot;
            mem_instr_n = 1'b0;
            pend_d_n    = 1'b0;
          end else begin
            mem_req_n       = '0;
            mem_req_n.addr  = f_slot;
            mem_instr_n     = 1'b1;
            pend_f_n        = 1'b0;
          end
          owner_d_n   = grant_d;
          last_d_n    = grant_d;
          mem_ready_n = 1'b1;
          cnt_n       = '0;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        if (resp_hit || resp_tmo) begin
          // Stores and timeouts return zero data
          if (resp_hit && (mem_req.wstrb == '0)) begin
            resp_data = mem_rdata;
          end
          mem_ready_n = 1'b0;
          state_n     = IDLE;
          if (owner_d) begin
            d_valid_n = 1'b1;
            d_err_n   = resp_tmo;
            d_rdata_n = resp_data;
          end else begin
            f_valid_n = 1'b1;
            f_err_n   = resp_tmo;
            f_rdata_n = resp_data;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Capture never collides with a grant of the same slot: both need opposite pend values
    if (f_req && !f_drop) begin
      pend_f_n = 1'b1;
      f_slot_n = f_addr;
    end
    if (d_req && !d_drop) begin
      pend_d_n       = 1'b1;
      d_slot_n.addr  = d_addr;
      d_slot_n.wdata = d_wdata;
      d_slot_n.wstrb = d_wstrb;
    end

    overrun_n = f_drop || d_drop;
    busy_n    = (state_n != IDLE) || pend_f_n || pend_d_n;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-by-cycle vectors for mem_arbiter (TIMEOUT=4),
// plus short hand-written sequences for grant alternation and D-port overrun.
module tb_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        f_valid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        overrun;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_valid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        overrun;
  logic        busy;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_instr;
  logic [31:0] mem_rdata;

  out_t act;
  in_t  i;
  out_t e;
  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  mem_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr),
    .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .overrun(overrun), .busy(busy),
    .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_instr(mem_instr), .mem_rdata(mem_rdata)
  );

  assign act = {mem_ready, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                f_valid, f_rdata, f_err, d_valid, d_rdata, d_err, overrun, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input in_t v);
    reset     = v.rst;
    f_req     = v.f_req;
    f_addr    = v.f_addr;
    d_req     = v.d_req;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    d_wstrb   = v.d_wstrb;
    mem_valid = v.mem_valid;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add();
    vecs.push_back({i, e});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    i = '0;
    i.rst = 1'b1;
    drive(i);

    // Reset, then a single fetch answered after one wait cycle
    i = '0; i.rst = 1'b1; e = '0; add(); add();
    i = '0; i.f_req = 1'b1; i.f_addr = 32'h100; e.busy = 1'b1; add();
    i = '0; e.mem_ready = 1'b1; e.mem_instr = 1'b1; e.mem_addr = 32'h100; add();
    i = '0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hDEADBEEF;
    e.mem_ready = 1'b0; e.f_valid = 1'b1; e.f_rdata = 32'hDEADBEEF; e.busy = 1'b0; add();
    i = '0; e.f_valid = 1'b0; add();

    // Simultaneous F and D after reset: F first, D store one idle cycle later
    i = '0; i.rst = 1'b1; e = '0; add();
    i = '0; i.f_req = 1'b1; i.f_addr = 32'h200; i.d_req = 1'b1; i.d_addr = 32'h300;
    i.d_wdata = 32'h12345678; i.d_wstrb = 4'hF; e.busy = 1'b1; add();
    i = '0; e.mem_ready = 1'b1; e.mem_instr = 1'b1; e.mem_addr = 32'h200; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hCAFEF00D;
    e.mem_ready = 1'b0; e.f_valid = 1'b1; e.f_rdata = 32'hCAFEF00D; add();
    i = '0; e.f_valid = 1'b0; e.mem_ready = 1'b1; e.mem_instr = 1'b0; e.mem_addr = 32'h300;
    e.mem_wdata = 32'h12345678; e.mem_wstrb = 4'hF; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hFFFFFFFF;
    e.mem_ready = 1'b0; e.d_valid = 1'b1; e.d_rdata = 32'h0; e.busy = 1'b0; add();
    i = '0; e.d_valid = 1'b0; add();

    // Owner strobe and D strobe on the response edge; tie then goes to D
    i = '0; i.f_req = 1'b1; i.f_addr = 32'h400; e.busy = 1'b1; add();
    i = '0; e.mem_ready = 1'b1; e.mem_instr = 1'b1; e.mem_addr = 32'h400;
    e.mem_wdata = 32'h0; e.mem_wstrb = 4'h0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h11111111; i.f_req = 1'b1; i.f_addr = 32'h500;
    i.d_req = 1'b1; i.d_addr = 32'h600; i.d_wdata = 32'hA5A5A5A5;
    e.mem_ready = 1'b0; e.f_valid = 1'b1; e.f_rdata = 32'h11111111; add();
    i = '0; e.f_valid = 1'b0; e.mem_ready = 1'b1; e.mem_instr = 1'b0; e.mem_addr = 32'h600;
    e.mem_wdata = 32'hA5A5A5A5; e.mem_wstrb = 4'h0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h22222222;
    e.mem_ready = 1'b0; e.d_valid = 1'b1; e.d_rdata = 32'h22222222; add();
    i = '0; e.d_valid = 1'b0; e.mem_ready = 1'b1; e.mem_instr = 1'b1; e.mem_addr = 32'h500;
    e.mem_wdata = 32'h0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h33333333;
    e.mem_ready = 1'b0; e.f_valid = 1'b1; e.f_rdata = 32'h33333333; e.busy = 1'b0; add();

    // D never answered: four ready cycles, error pulse, late mem_valid ignored
    i = '0; i.d_req = 1'b1; i.d_addr = 32'h900; i.d_wdata = 32'h0BADF00D; i.d_wstrb = 4'h1;
    e.f_valid = 1'b0; e.busy = 1'b1; add();
    i = '0; e.mem_ready = 1'b1; e.mem_instr = 1'b0; e.mem_addr = 32'h900;
    e.mem_wdata = 32'h0BADF00D; e.mem_wstrb = 4'h1; add();
    i = '0; add(); add(); add();
    i = '0; e.mem_ready = 1'b0; e.d_valid = 1'b1; e.d_err = 1'b1; e.d_rdata = 32'h0;
    e.busy = 1'b0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h44444444; e.d_valid = 1'b0; e.d_err = 1'b0; add();
    i = '0; add();

    // Second fetch strobe while the first is still pending: one overrun, one response
    i = '0; i.f_req = 1'b1; i.f_addr = 32'hA00; e.busy = 1'b1; add();
    i = '0; i.f_req = 1'b1; i.f_addr = 32'hB00; e.mem_ready = 1'b1; e.mem_instr = 1'b1;
    e.mem_addr = 32'hA00; e.mem_wdata = 32'h0; e.mem_wstrb = 4'h0; e.overrun = 1'b1; add();
    i = '0; e.overrun = 1'b0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h55555555;
    e.mem_ready = 1'b0; e.f_valid = 1'b1; e.f_rdata = 32'h55555555; e.busy = 1'b0; add();
    i = '0; e.f_valid = 1'b0; add(); add();

    // Reset during WAIT with F still pending: everything cleared, no pulses
    i = '0; i.f_req = 1'b1; i.f_addr = 32'hE00; i.d_req = 1'b1; i.d_addr = 32'hD00;
    i.d_wdata = 32'h77; i.d_wstrb = 4'hF; e.busy = 1'b1; add();
    i = '0; e.mem_ready = 1'b1; e.mem_instr = 1'b0; e.mem_addr = 32'hD00;
    e.mem_wdata = 32'h77; e.mem_wstrb = 4'hF; add();
    i = '0; i.rst = 1'b1; e = '0; add();
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'h99; add();
    i = '0; add();

    foreach (vecs[k]) begin
      drive(vecs[k].i);
      tick();
      n_vec++;
      if (act !== vecs[k].o) begin
        n_bad++;
        $display("FAIL vec %0d: got %h want %h", k, act, vecs[k].o);
      end
    end

    // Repeated simultaneous requests: grants go F, D, F, D
    for (int r = 0; r < 2; r++) begin
      i = '0; i.f_req = 1'b1; i.f_addr = 32'h1000 + 32'(r);
      i.d_req = 1'b1; i.d_addr = 32'h2000 + 32'(r);
      drive(i); tick();
      i = '0; drive(i); tick();
      chk("alt_f_ready", 32'(mem_ready), 32'd1);
      chk("alt_f_instr", 32'(mem_instr), 32'd1);
      chk("alt_f_addr", mem_addr, 32'h1000 + 32'(r));
      i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hF0 + 32'(r); drive(i); tick();
      chk("alt_f_valid", 32'(f_valid), 32'd1);
      chk("alt_f_rdata", f_rdata, 32'hF0 + 32'(r));
      i = '0; drive(i); tick();
      chk("alt_d_instr", 32'(mem_instr), 32'd0);
      chk("alt_d_addr", mem_addr, 32'h2000 + 32'(r));
      i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hD0 + 32'(r); drive(i); tick();
      chk("alt_d_valid", 32'(d_valid), 32'd1);
      chk("alt_d_rdata", d_rdata, 32'hD0 + 32'(r));
      i = '0; drive(i); tick();
      chk("alt_idle_busy", 32'(busy), 32'd0);
    end

    // D strobe repeated while its slot is pending
    i = '0; i.d_req = 1'b1; i.d_addr = 32'h3000; drive(i); tick();
    i.d_addr = 32'h3100; drive(i); tick();
    chk("d_ovr_pulse", 32'(overrun), 32'd1);
    chk("d_ovr_ready", 32'(mem_ready), 32'd1);
    chk("d_ovr_addr", mem_addr, 32'h3000);
    i = '0; i.mem_valid = 1'b1; i.mem_rdata = 32'hABCD; drive(i); tick();
    chk("d_ovr_valid", 32'(d_valid), 32'd1);
    chk("d_ovr_rdata", d_rdata, 32'hABCD);
    chk("d_ovr_clear", 32'(overrun), 32'd0);
    i = '0; drive(i); tick();
    chk("d_ovr_no_second", 32'(mem_ready), 32'd0);
    chk("d_ovr_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
